// File: rtl/mem_arbiter_if.sv
// Core-side request/response and memory-side bus of the instruction/data memory arbiter.
// The arbiter takes the slave view; whatever drives requests and models memory takes the master view.
interface mem_arbiter_if;
    logic        iIReq;
    logic [31:0] iIAddr;
    logic        oIGnt;
    logic        oIValid;
    logic [31:0] oIData;
    logic        oIErr;

    logic        iDReq;
    logic        iDReadnWrite;
    logic [31:0] iDAddr;
    logic [31:0] iDData;
    logic        oDGnt;
    logic        oDValid;
    logic [31:0] oDData;
    logic        oDErr;

    logic        oMemEn;
    logic        oMemReadnWrite;
    logic [31:0] oMemAddr;
    logic [31:0] oMemData;
    logic [31:0] iMemData;

    modport slave (
        input  iIReq, iIAddr, iDReq, iDReadnWrite, iDAddr, iDData, iMemData,
        output oIGnt, oIValid, oIData, oIErr,
        output oDGnt, oDValid, oDData, oDErr,
        output oMemEn, oMemReadnWrite, oMemAddr, oMemData
    );

    modport master (
        output iIReq, iIAddr, iDReq, iDReadnWrite, iDAddr, iDData, iMemData,
        input  oIGnt, oIValid, oIData, oIErr,
        input  oDGnt, oDValid, oDData, oDErr,
        input  oMemEn, oMemReadnWrite, oMemAddr, oMemData
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one transaction at a time,
// with alignment/range checking, a programmable wait-state window and fetch starvation protection.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int MEM_WORDS   = 4096,
    parameter int STARVE_MAX  = 4
) (
    input logic          iClk,
    input logic          nRst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES);
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [30:0] WORD_LIM   = 31'(MEM_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [3:0]  wait_q, wait_d;
    logic        owner_q, owner_d;     // 1 = load/store port owns the transaction
    logic        rnw_q, rnw_d;
    logic        err_q, err_d;
    logic [29:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        i_win, d_win, req_err, last_access;
    logic [31:0] req_addr;

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            wait_q   <= '0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
            owner_q  <= owner_d;
        end
    end

    always_ff @(posedge iClk) begin
        rnw_q   <= rnw_d;
        err_q   <= err_d;
        word_q  <= word_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        wait_d   = wait_q;
        owner_d  = owner_q;
        rnw_d    = rnw_q;
        err_d    = err_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        i_win       = 1'b0;
        d_win       = 1'b0;
        req_addr    = bus.iIAddr;
        req_err     = 1'b0;
        last_access = (wait_q == WAIT_LAST);

        bus.oIGnt          = 1'b0;
        bus.oIValid        = 1'b0;
        bus.oIData         = '0;
        bus.oIErr          = 1'b0;
        bus.oDGnt          = 1'b0;
        bus.oDValid        = 1'b0;
        bus.oDData         = '0;
        bus.oDErr          = 1'b0;
        bus.oMemEn         = 1'b0;
        bus.oMemReadnWrite = 1'b0;
        bus.oMemAddr       = '0;
        bus.oMemData       = '0;

        unique case (state_q)
            IDLE: begin
                i_win    = bus.iIReq && (!bus.iDReq || starve_q == STARVE_LIM);
                d_win    = bus.iDReq && !i_win;
                req_addr = d_win ? bus.iDAddr : bus.iIAddr;
                req_err  = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr[31:2]} >= WORD_LIM);

                if (i_win || !bus.iIReq) begin
                    starve_d = '0;
                end else if (d_win && starve_q != STARVE_LIM) begin
                    starve_d = starve_q + 4'd1;
                end

                bus.oIGnt = i_win;
                bus.oDGnt = d_win;

                if (i_win || d_win) begin
                    owner_d = d_win;
                    rnw_d   = i_win || bus.iDReadnWrite;
                    word_d  = req_addr[31:2];
                    wdata_d = d_win ? bus.iDData : '0;
                    err_d   = req_err;
                    rdata_d = '0;
                    wait_d  = '0;
                    state_d = req_err ? RESP : ACCESS;
                end
            end

            ACCESS: begin
                // Stores strobe only on the last wait-state cycle so memory sees exactly one write.
                bus.oMemEn         = rnw_q || last_access;
                bus.oMemReadnWrite = rnw_q;
                bus.oMemAddr       = {2'b00, word_q};
                bus.oMemData       = wdata_q;
                if (last_access) begin
                    if (rnw_q) begin
                        rdata_d = bus.iMemData;
                    end
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            RESP: begin
                bus.oIValid = !owner_q;
                bus.oIData  = owner_q ? '0 : rdata_q;
                bus.oIErr   = !owner_q && err_q;
                bus.oDValid = owner_q;
                bus.oDData  = owner_q ? rdata_q : '0;
                bus.oDErr   = owner_q && err_q;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Quiet every output during reset so no grant or memory write escapes a reset cycle.
        if (!nRst) begin
            bus.oIGnt          = 1'b0;
            bus.oIValid        = 1'b0;
            bus.oIData         = '0;
            bus.oIErr          = 1'b0;
            bus.oDGnt          = 1'b0;
            bus.oDValid        = 1'b0;
            bus.oDData         = '0;
            bus.oDErr          = 1'b0;
            bus.oMemEn         = 1'b0;
            bus.oMemReadnWrite = 1'b0;
            bus.oMemAddr       = '0;
            bus.oMemData       = '0;
        end
    end

endmodule
